// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_ctrl
// Purpose  : Runtime controller for a posedge/negedge clock divider pair.
//            It owns the divide ratio and the enable of the divider. New
//            ratios arrive over a valid/ready handshake and are checked
//            for legality. A new ratio is applied only at an output-period
//            boundary, so the divided clock never emits a runt pulse.
// Ports    : clk        - source clock, all logic on posedge
//            arstn      - synchronous active-low reset
//            run        - level request, 1 = run, 0 = stop at period end
//            cfg_valid  - new ratio offered
//            cfg_ratio  - requested ratio
//            cfg_ready  - ratio can be accepted this cycle (OFF/RUN)
//            cfg_err    - one-cycle pulse, accepted ratio was illegal
//            div_en     - divider enable
//            div_clr    - one-cycle synchronous clear of divider counters
//            div_ratio  - applied ratio
//            high_flip  - div_ratio-1
//            low_flip   - (div_ratio-1)>>1
//            cnt        - mirror of divider posedge counter
//            tick       - end-of-period pulse (cnt==high_flip, div_en=1)
//            busy       - controller in DRAIN or LOAD
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
  parameter int RW            = 8,
  parameter int MAX_RATIO     = 255,
  parameter int DEFAULT_RATIO = 5
) (
  input  logic          clk,
  input  logic          arstn,
  input  logic          run,
  input  logic          cfg_valid,
  input  logic [RW-1:0] cfg_ratio,
  output logic          cfg_ready,
  output logic          cfg_err,
  output logic          div_en,
  output logic          div_clr,
  output logic [RW-1:0] div_ratio,
  output logic [RW-1:0] high_flip,
  output logic [RW-1:0] low_flip,
  output logic [RW-1:0] cnt,
  output logic          tick,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_LOAD  = 2'd3
  } state_t;

  localparam logic [RW-1:0] c_max_ratio = RW'(MAX_RATIO);
  localparam logic [RW-1:0] c_min_ratio = RW'(2);
  localparam logic [RW-1:0] c_one       = RW'(1);
  localparam logic [RW-1:0] c_def_ratio = RW'(DEFAULT_RATIO);
  localparam logic [RW-1:0] c_def_high  = RW'(DEFAULT_RATIO - 1);
  localparam logic [RW-1:0] c_def_low   = RW'((DEFAULT_RATIO - 1) / 2);

  state_t        state_q, state_d;
  logic [RW-1:0] ratio_q, ratio_d;
  logic [RW-1:0] high_q, high_d;
  logic [RW-1:0] low_q, low_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [RW-1:0] pend_ratio_q, pend_ratio_d;
  logic          err_q, err_d;

  logic          xfer;
  logic          legal;
  logic          end_of_period;
  logic [RW-1:0] cnt_next;

  assign cfg_ready     = (state_q == ST_OFF) || (state_q == ST_RUN);
  assign xfer          = cfg_valid && cfg_ready;
  assign legal         = (cfg_ratio >= c_min_ratio) && (cfg_ratio <= c_max_ratio);
  assign div_en        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign div_clr       = (state_q == ST_LOAD);
  assign busy          = (state_q == ST_DRAIN) || (state_q == ST_LOAD);
  assign end_of_period = div_en && (cnt_q == high_q);
  assign tick          = end_of_period;
  assign cnt_next      = (cnt_q == high_q) ? '0 : cnt_q + c_one;

  assign cfg_err   = err_q;
  assign div_ratio = ratio_q;
  assign high_flip = high_q;
  assign low_flip  = low_q;
  assign cnt       = cnt_q;

  always_comb begin
    state_d      = state_q;
    ratio_d      = ratio_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_ratio_d = pend_ratio_q;
    err_d        = xfer && !legal;

    case (state_q)
      ST_OFF: begin
        cnt_d = '0;
        // Divider is idle, so a legal ratio can be applied immediately;
        // if run rises in the same cycle the following LOAD already sees it.
        if (xfer && legal) begin
          ratio_d = cfg_ratio;
        end
        if (run) begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_next;
        if (xfer && legal) begin
          pend_d       = 1'b1;
          pend_ratio_d = cfg_ratio;
          state_d      = ST_DRAIN;
        end
        if (!run) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_next;
        // Apply the pending ratio on the edge into LOAD so it is already
        // visible while the divider counters are being cleared.
        if (end_of_period) begin
          state_d = ST_LOAD;
          if (pend_q) begin
            ratio_d = pend_ratio_q;
          end
          pend_d = 1'b0;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = run ? ST_RUN : ST_OFF;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_OFF;
      end
    endcase
  end

  // Flip points are registered with the ratio, keeping cfg_ratio off any
  // combinational path to the outputs.
  assign high_d = ratio_d - c_one;
  assign low_d  = high_d >> 1;

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q      <= ST_OFF;
      ratio_q      <= c_def_ratio;
      high_q       <= c_def_high;
      low_q        <= c_def_low;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      pend_ratio_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ratio_q      <= ratio_d;
      high_q       <= high_d;
      low_q        <= low_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_ratio_q <= pend_ratio_d;
      err_q        <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_ctrl
// Purpose  : Directed self-checking bench for clk_div_ctrl. Inputs change
//            1 time unit after a posedge, outputs are sampled at that point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

  localparam int RW = 8;

  logic          clk;
  logic          arstn;
  logic          run;
  logic          cfg_valid;
  logic [RW-1:0] cfg_ratio;
  logic          cfg_ready;
  logic          cfg_err;
  logic          div_en;
  logic          div_clr;
  logic [RW-1:0] div_ratio;
  logic [RW-1:0] high_flip;
  logic [RW-1:0] low_flip;
  logic [RW-1:0] cnt;
  logic          tick;
  logic          busy;

  int total = 0;
  int bad   = 0;

  clk_div_ctrl #(
    .RW           (RW),
    .MAX_RATIO    (200),
    .DEFAULT_RATIO(5)
  ) u_dut (
    .clk      (clk),
    .arstn    (arstn),
    .run      (run),
    .cfg_valid(cfg_valid),
    .cfg_ratio(cfg_ratio),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .div_en   (div_en),
    .div_clr  (div_clr),
    .div_ratio(div_ratio),
    .high_flip(high_flip),
    .low_flip (low_flip),
    .cnt      (cnt),
    .tick     (tick),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps through n+1 cycles of RUN starting at cnt=0, checking the wrap.
  task automatic run_period(input int n);
    for (int i = 0; i <= n; i++) begin
      step();
      check("per_cnt", int'(cnt), i % n);
      check("per_tick", int'(tick), ((i % n) == n - 1) ? 1 : 0);
      check("per_en", int'(div_en), 1);
    end
  endtask

  initial begin
    arstn     = 1'b0;
    run       = 1'b0;
    cfg_valid = 1'b0;
    cfg_ratio = '0;
    step();
    step();

    // Reset state
    check("rst_ratio", int'(div_ratio), 5);
    check("rst_high", int'(high_flip), 4);
    check("rst_low", int'(low_flip), 2);
    check("rst_cnt", int'(cnt), 0);
    check("rst_en", int'(div_en), 0);
    check("rst_clr", int'(div_clr), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_err", int'(cfg_err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cfg_ready), 1);

    // Start: one LOAD cycle then period 5
    arstn = 1'b1;
    run   = 1'b1;
    step();
    check("ld1_clr", int'(div_clr), 1);
    check("ld1_en", int'(div_en), 0);
    check("ld1_busy", int'(busy), 1);
    check("ld1_cnt", int'(cnt), 0);
    run_period(5);

    // Ratio change at cnt=1 -> drain to end of period, load 7
    step();
    check("c7_cnt1", int'(cnt), 1);
    cfg_valid = 1'b1;
    cfg_ratio = 8'd7;
    step();
    cfg_valid = 1'b0;
    check("c7_ready", int'(cfg_ready), 0);
    check("c7_busy", int'(busy), 1);
    check("c7_cnt2", int'(cnt), 2);
    check("c7_ratio_hold", int'(div_ratio), 5);
    step();
    check("c7_cnt3", int'(cnt), 3);
    step();
    check("c7_cnt4", int'(cnt), 4);
    check("c7_tick", int'(tick), 1);
    step();
    check("c7_ld_clr", int'(div_clr), 1);
    check("c7_ld_ratio", int'(div_ratio), 7);
    check("c7_ld_high", int'(high_flip), 6);
    check("c7_ld_low", int'(low_flip), 3);
    check("c7_ld_cnt", int'(cnt), 0);
    run_period(7);

    // Illegal ratios: 1 and MAX_RATIO+1
    cfg_valid = 1'b1;
    cfg_ratio = 8'd1;
    step();
    cfg_valid = 1'b0;
    check("e1_err", int'(cfg_err), 1);
    check("e1_ratio", int'(div_ratio), 7);
    check("e1_busy", int'(busy), 0);
    check("e1_en", int'(div_en), 1);
    cfg_valid = 1'b1;
    cfg_ratio = 8'd201;
    step();
    cfg_valid = 1'b0;
    check("e2_err", int'(cfg_err), 1);
    check("e2_ratio", int'(div_ratio), 7);
    check("e2_busy", int'(busy), 0);
    step();
    check("e2_err_clear", int'(cfg_err), 0);
    check("e2_ready", int'(cfg_ready), 1);

    // Back to ratio 5
    cfg_valid = 1'b1;
    cfg_ratio = 8'd5;
    step();
    cfg_valid = 1'b0;
    begin
      int n = 0;
      while (!div_clr && n < 20) begin
        step();
        n++;
      end
    end
    check("r5_load_seen", int'(div_clr), 1);
    check("r5_ratio", int'(div_ratio), 5);
    step();
    check("r5_cnt0", int'(cnt), 0);

    // Stop at cnt=0: period completes, LOAD, then OFF
    run = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("stop_cnt", int'(cnt), i);
      check("stop_en", int'(div_en), 1);
      check("stop_busy", int'(busy), 1);
    end
    check("stop_tick", int'(tick), 1);
    step();
    check("stop_ld_en", int'(div_en), 0);
    check("stop_ld_clr", int'(div_clr), 1);
    step();
    check("off_en", int'(div_en), 0);
    check("off_cnt", int'(cnt), 0);
    check("off_busy", int'(busy), 0);
    check("off_clr", int'(div_clr), 0);
    step();
    check("off_hold_cnt", int'(cnt), 0);

    // OFF: ratio 6 together with run=1
    cfg_valid = 1'b1;
    cfg_ratio = 8'd6;
    run       = 1'b1;
    step();
    cfg_valid = 1'b0;
    check("c6_ld_clr", int'(div_clr), 1);
    check("c6_ratio", int'(div_ratio), 6);
    check("c6_high", int'(high_flip), 5);
    check("c6_low", int'(low_flip), 2);
    run_period(6);

    // Reset during DRAIN with pending ratio 9
    cfg_valid = 1'b1;
    cfg_ratio = 8'd9;
    step();
    cfg_valid = 1'b0;
    check("p9_busy", int'(busy), 1);
    step();
    arstn = 1'b0;
    step();
    arstn = 1'b1;
    check("p9_rst_ratio", int'(div_ratio), 5);
    check("p9_rst_busy", int'(busy), 0);
    check("p9_rst_en", int'(div_en), 0);
    check("p9_rst_cnt", int'(cnt), 0);
    check("p9_rst_high", int'(high_flip), 4);
    step();
    check("p9_ld_clr", int'(div_clr), 1);
    check("p9_ld_ratio", int'(div_ratio), 5);
    run_period(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
